// File: rtl/queue_dispatcher_if.sv
// Packet stream and queue-bank write lanes shared by the dispatcher and its neighbours.
interface queue_dispatcher_if #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_SIZE        = 678
);
  logic [DATA_SIZE-1:0]                    packet_in;
  logic                                    packet_in_valid;
  logic                                    packet_in_ready;
  logic [NUMBER_OF_QUEUES-1:0]             full;
  logic [NUMBER_OF_QUEUES-1:0]             lastElem;
  logic [DATA_SIZE*NUMBER_OF_QUEUES/2-1:0] dispatcher_to_queues_packets;
  logic [NUMBER_OF_QUEUES-1:0]             dispatcher_to_queues_valid;

  modport master (
    output packet_in, packet_in_valid, full, lastElem,
    input  packet_in_ready, dispatcher_to_queues_packets, dispatcher_to_queues_valid
  );

  modport slave (
    input  packet_in, packet_in_valid, full, lastElem,
    output packet_in_ready, dispatcher_to_queues_packets, dispatcher_to_queues_valid
  );
endinterface

// File: rtl/queue_dispatcher.sv
// Writer side of the per-criticality queue bank: one holding register, then a per-lane write stage.
// Define DISPATCHER_DROP_ON_FULL_EN to drop blocked packets instead of stalling.
module queue_dispatcher #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_SIZE        = 678,
  parameter int ID_OFFSET        = 0,
  parameter int ID_WIDTH         = 2,
  parameter int REGISTER_SIZE    = 32
) (
  input  logic                                              clock,
  input  logic                                              reset,
  queue_dispatcher_if.slave                                 bus,
  input  logic                                              counters_clear,
  output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]    accepted_count,
  output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]    dropped_count
);
  localparam int DEST_W = $clog2(NUMBER_OF_QUEUES);
  localparam int LANES  = NUMBER_OF_QUEUES / 2;

  typedef enum logic [1:0] {ST_INIT, ST_EMPTY, ST_HELD} state_t;

  state_t                                           state_reg, state_next;
  logic [DATA_SIZE-1:0]                             h_data_reg;
  logic [DEST_W-1:0]                                h_dest_reg;
  logic [DEST_W-1:0]                                dest_in;
  logic [ID_WIDTH-1:0]                              id_field;
  logic [LANES*DATA_SIZE-1:0]                       lanes_reg;
  logic [NUMBER_OF_QUEUES-1:0]                      strobe_reg;
  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   accepted_reg;
  logic                                             blocked;
  logic                                             issue;
  logic                                             drop;
  logic                                             ready;
  logic                                             handshake;
  wire  [NUMBER_OF_QUEUES-1:0]                      accept_hit;

  // Out-of-range IDs fold onto the last queue.
  always_comb begin
    id_field = bus.packet_in[ID_OFFSET +: ID_WIDTH];
    if (32'(id_field) >= 32'(NUMBER_OF_QUEUES))
      dest_in = DEST_W'(NUMBER_OF_QUEUES - 1);
    else
      dest_in = DEST_W'(id_field);
  end

  // A strobe landing on a queue with one free slot fills it before full can rise.
  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    issue      = 1'b0;
    drop       = 1'b0;
    blocked    = bus.full[h_dest_reg] | (strobe_reg[h_dest_reg] & bus.lastElem[h_dest_reg]);
    case (state_reg)
      ST_INIT: state_next = ST_EMPTY;
      ST_EMPTY: begin
        ready = 1'b1;
        if (bus.packet_in_valid)
          state_next = ST_HELD;
      end
      ST_HELD: begin
        issue = !blocked;
`ifdef DISPATCHER_DROP_ON_FULL_EN
        drop  = blocked;
`endif
        ready = issue | drop;
        if (ready && !bus.packet_in_valid)
          state_next = ST_EMPTY;
      end
      default: state_next = ST_INIT;
    endcase
  end

  assign handshake           = ready & bus.packet_in_valid;
  assign bus.packet_in_ready = ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_INIT;
      h_data_reg <= '0;
      h_dest_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (handshake) begin
        h_data_reg <= bus.packet_in;
        h_dest_reg <= dest_in;
      end
    end
  end

  for (genvar gi = 0; gi < NUMBER_OF_QUEUES; gi++) begin : g_accept
    assign accept_hit[gi] = issue && (h_dest_reg == DEST_W'(gi));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lanes_reg    <= '0;
      strobe_reg   <= '0;
      accepted_reg <= '0;
    end else begin
      strobe_reg <= accept_hit;
      for (int k = 0; k < LANES; k++) begin
        if (accept_hit[2*k] || accept_hit[2*k+1])
          lanes_reg[k*DATA_SIZE +: DATA_SIZE] <= h_data_reg;
      end
      for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
        if (counters_clear)
          accepted_reg[q] <= '0;
        else if (accept_hit[q])
          accepted_reg[q] <= accepted_reg[q] + REGISTER_SIZE'(1);
      end
    end
  end

  assign bus.dispatcher_to_queues_packets = lanes_reg;
  assign bus.dispatcher_to_queues_valid   = strobe_reg;
  assign accepted_count                   = accepted_reg;

`ifdef DISPATCHER_DROP_ON_FULL_EN
  wire  [NUMBER_OF_QUEUES-1:0]                      drop_hit;
  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   dropped_reg;

  for (genvar gi = 0; gi < NUMBER_OF_QUEUES; gi++) begin : g_drop
    assign drop_hit[gi] = drop && (h_dest_reg == DEST_W'(gi));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dropped_reg <= '0;
    end else begin
      for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
        if (counters_clear)
          dropped_reg[q] <= '0;
        else if (drop_hit[q])
          dropped_reg[q] <= dropped_reg[q] + REGISTER_SIZE'(1);
      end
    end
  end

  assign dropped_count = dropped_reg;
`else
  assign dropped_count = '0;
`endif
endmodule

// File: doc/queue_dispatcher.md
Name: queue_dispatcher

Overview:
- Writer side of the per-criticality queue bank. Takes one incoming memory-request packet per cycle on a valid/ready stream and decodes its queue ID.
- Drives the packet onto the shared lane of the destination queue pair, with a one-cycle write strobe for that queue.
- Honours queue full status and keeps per-queue accepted-packet counters for the regulation logic.

Parameters:
NUMBER_OF_QUEUES, 4, number of queues fed; must be even (two queues share one packet lane)
DATA_SIZE, 678, packet width in bits
ID_OFFSET, 0, LSB position of the queue-ID field inside the packet
ID_WIDTH, 2, width of the queue-ID field
REGISTER_SIZE, 32, width of each statistics counter

Ports:
clock  in  1  single clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
packet_in  in  DATA_SIZE  incoming packet
packet_in_valid  in  1  packet_in is valid
packet_in_ready  out  1  dispatcher accepts packet_in this cycle
full  in  NUMBER_OF_QUEUES  queue q holds QUEUE_LENGTH entries
lastElem  in  NUMBER_OF_QUEUES  queue q holds QUEUE_LENGTH-1 entries
dispatcher_to_queues_packets  out  DATA_SIZE*NUMBER_OF_QUEUES/2  lane k (bits k*DATA_SIZE +: DATA_SIZE) feeds queues 2k and 2k+1
dispatcher_to_queues_valid  out  NUMBER_OF_QUEUES  one-cycle write strobe per queue
counters_clear  in  1  synchronous clear of all counters
accepted_count  out  NUMBER_OF_QUEUES x REGISTER_SIZE  packets written per queue
dropped_count  out  NUMBER_OF_QUEUES x REGISTER_SIZE  packets dropped per queue (see Optional Feature)

Behaviour:
- Reset (reset low, asynchronous): holding register empty, all lanes 0, all valid bits 0, all counters 0. packet_in_ready is 1 one cycle after reset deasserts.
- Reset asserted mid-operation discards any held packet; no strobe is emitted for it.
- Stage 1, holding register H:
  - A handshake occurs when packet_in_valid and packet_in_ready are both high at a clock edge.
  - On handshake, H captures the packet and dest = packet_in[ID_OFFSET +: ID_WIDTH].
  - IDs >= NUMBER_OF_QUEUES map to queue NUMBER_OF_QUEUES-1.
- Issue condition for queue q = dest: H valid, full[q] low, and NOT (dispatcher_to_queues_valid[q] high AND lastElem[q] high). The second term covers the in-flight write not yet reflected in full.
- Stage 2, output registers:
  - On issue, at the next edge lane dest>>1 loads the packet, valid[dest] goes high for exactly one cycle, and accepted_count[dest] increments.
  - On that same edge H empties, or reloads if a new handshake occurs.
- Lanes not written hold their previous value. At most one valid bit is high per cycle.
- packet_in_ready = !H_valid OR issue. This gives full throughput of 1 packet/cycle when no queue is blocked.
- Latency: handshake at edge E0 gives a strobe visible in the cycle after E1 when the target is not blocked. Blocked cycles add one cycle each.
- Packets are never reordered. A blocked head stalls all destinations (no bypass).
- Counters:
  - Wrap modulo 2^REGISTER_SIZE.
  - counters_clear takes priority over a simultaneous increment; the result is 0 and that increment is lost.
- full and lastElem are sampled combinationally in the issue cycle only.

Optional Feature:
- Macro: DISPATCHER_DROP_ON_FULL_EN.
- Defined: when H is valid and its queue is blocked, the packet is dropped at the next edge and dropped_count[dest] increments. No strobe is emitted, and H is free that same edge, so ready stays 1.
- Undefined: the dispatcher stalls as described above and dropped_count is tied to 0.

Test Plan:
- Reset low with packet_in_valid=1 -> ready=0 during reset; valid=0, lanes=0, counters=0. Ready goes 1 one cycle after release.
- Back-to-back packets with IDs 0,1,2,3, all queues empty -> strobes valid=0001,0010,0100,1000 on consecutive cycles. Lane 0 carries packets 0,1; lane 1 carries packets 2,3. accepted_count=1 each.
- full[2]=1 with the packet for queue 2 held, then a packet for queue 0 offered -> ready=0 and no strobe. Release full[2] -> queue-2 strobe, then queue-0 strobe on the next cycle (in order).
- Two consecutive packets to queue 1 with lastElem[1]=1 on the first strobe cycle -> second packet is not issued that cycle and is issued after lastElem/full clear.
- ID=5 with NUMBER_OF_QUEUES=4, ID_WIDTH=3 -> valid=1000. counters_clear in the same cycle as an increment -> accepted_count[3]=0.
- DISPATCHER_DROP_ON_FULL_EN defined, full[0]=1, three packets to queue 0 -> no strobes, dropped_count[0]=3, ready stays 1.
